// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes a MIPS instruction into registered ALU controls and
// operands, stalling a consumer of a just-issued lw until the load has drained.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic [4:0]  ALU_op,
  output logic [31:0] arg1,
  output logic [31:0] arg2,
  output logic [4:0]  shamt,
  output logic [4:0]  dest_reg,
  output logic        is_load,
  output logic        illegal
);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_NOR = 5'd4, OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                         OP_SLT = 5'd8, OP_LUI = 5'd9, OP_BNE = 5'd10, OP_BGTZ = 5'd11,
                         OP_BGEZ = 5'd12;
  typedef enum logic [1:0] {IDLE, HELD, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [4:0]  trk_q, trk_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  alu_op_q, alu_op_d, shamt_q, shamt_d, dest_q, dest_d;
  logic [31:0] arg1_q, arg1_d, arg2_q, arg2_d;
  logic        load_q, load_d, ill_q, ill_d;
  logic [5:0]  opc, fn;
  logic [31:0] sext, zext;
  logic [4:0]  dec_op, dec_dst, rs_idx, rt_idx;
  logic [31:0] dec_a2;
  logic        dec_ld, dec_ill, reads_rt, hazard, in_xfer, out_xfer;
  assign opc    = instr[31:26];
  assign fn     = instr[5:0];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];
  assign sext   = {{16{instr[15]}}, instr[15:0]};
  assign zext   = {16'h0000, instr[15:0]};
  always_comb begin
    dec_op   = OP_ADD;
    dec_a2   = '0;
    dec_dst  = '0;
    dec_ld   = 1'b0;
    dec_ill  = 1'b0;
    reads_rt = 1'b0;
    case (opc)
      6'h00: begin
        dec_a2   = rt_data;
        dec_dst  = instr[15:11];
        reads_rt = 1'b1;
        case (fn)
          6'h20, 6'h21: dec_op = OP_ADD;
          6'h22, 6'h23: dec_op = OP_SUB;
          6'h24:        dec_op = OP_AND;
          6'h25:        dec_op = OP_OR;
          6'h27:        dec_op = OP_NOR;
          6'h00:        dec_op = OP_SLL;
          6'h02:        dec_op = OP_SRL;
          6'h03:        dec_op = OP_SRA;
          6'h2a:        dec_op = OP_SLT;
          default:      dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin dec_a2 = sext; dec_dst = rt_idx; end
      6'h0a: begin dec_op = OP_SLT; dec_a2 = sext; dec_dst = rt_idx; end
      6'h0c: begin dec_op = OP_AND; dec_a2 = zext; dec_dst = rt_idx; end
      6'h0d: begin dec_op = OP_OR;  dec_a2 = zext; dec_dst = rt_idx; end
      6'h0f: begin dec_op = OP_LUI; dec_a2 = zext; dec_dst = rt_idx; end
      6'h23: begin dec_a2 = sext; dec_dst = rt_idx; dec_ld = 1'b1; end
      6'h2b: begin dec_a2 = sext; reads_rt = 1'b1; end
      6'h04: begin dec_op = OP_SUB; dec_a2 = rt_data; reads_rt = 1'b1; end
      6'h05: begin dec_op = OP_BNE; dec_a2 = rt_data; reads_rt = 1'b1; end
      6'h07: dec_op = OP_BGTZ;
      6'h01: begin
        dec_op  = OP_BGEZ;
        dec_ill = (rt_idx != 5'd1);
      end
      default: dec_ill = 1'b1;
    endcase
  end
  // Only a load still in the output register or just handed to the ALU can
  // leave its destination unavailable to the instruction being issued.
  assign hazard   = (state_q != IDLE) && (trk_q != 5'd0) &&
                    ((trk_q == rs_idx) || (reads_rt && trk_q == rt_idx));
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;
  always_comb begin
    state_d     = flush ? IDLE :
                  (in_xfer && dec_ld) ? HELD :
                  (state_q == HELD && out_xfer) ? DRAIN :
                  (state_q == DRAIN) ? IDLE : state_q;
    trk_d       = (in_xfer && dec_ld) ? rt_idx : trk_q;
    out_valid_d = flush ? 1'b0 : in_xfer ? 1'b1 : out_xfer ? 1'b0 : out_valid_q;
    alu_op_d    = in_xfer ? (dec_ill ? OP_ADD : dec_op) : alu_op_q;
    arg1_d      = in_xfer ? (dec_ill ? 32'h0 : rs_data) : arg1_q;
    arg2_d      = in_xfer ? (dec_ill ? 32'h0 : dec_a2) : arg2_q;
    shamt_d     = in_xfer ? instr[10:6] : shamt_q;
    dest_d      = in_xfer ? (dec_ill ? 5'd0 : dec_dst) : dest_q;
    load_d      = in_xfer ? (dec_ld && !dec_ill) : load_q;
    ill_d       = in_xfer ? dec_ill : ill_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      trk_q       <= '0;
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      arg1_q      <= '0;
      arg2_q      <= '0;
      shamt_q     <= '0;
      dest_q      <= '0;
      load_q      <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      trk_q       <= trk_d;
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      arg1_q      <= arg1_d;
      arg2_q      <= arg2_d;
      shamt_q     <= shamt_d;
      dest_q      <= dest_d;
      load_q      <= load_d;
      ill_q       <= ill_d;
    end
  end
  assign out_valid = out_valid_q;
  assign ALU_op    = alu_op_q;
  assign arg1      = arg1_q;
  assign arg2      = arg2_q;
  assign shamt     = shamt_q;
  assign dest_reg  = dest_q;
  assign is_load   = load_q;
  assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scenario tasks plus a decode scoreboard filled on input
// transfers and drained on output transfers.
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
  logic        in_valid = 1'b0, out_ready = 1'b1, flush = 1'b0;
  logic        in_ready, out_valid, is_load, illegal;
  logic [4:0]  ALU_op, shamt, dest_reg;
  logic [31:0] arg1, arg2;
  int checks = 0, passed = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [4:0]  sh;
    logic [4:0]  dst;
    logic        ld;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  localparam int N = 24;
  localparam logic [31:0] TBL [N] = '{
    32'h00221820, 32'h00221821, 32'h00221822, 32'h00221823, 32'h00221824,
    32'h00221825, 32'h00221827, 32'h0022182A, 32'h00021900, 32'h00021902,
    32'h00021903, 32'h00221826, 32'h2004FFFF, 32'h24058000, 32'h8C220000,
    32'h00421820, 32'h2826FFF0, 32'h3004FFFF, 32'h34278001, 32'h3C081234,
    32'hAC220004, 32'h10220003, 32'h14220003, 32'h04200002
  };
  localparam logic [31:0] EXTRA [4] = '{32'h1C200005, 32'h04210002, 32'hFC000000, 32'h08000000};

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .ALU_op(ALU_op), .arg1(arg1), .arg2(arg2), .shamt(shamt),
    .dest_reg(dest_reg), .is_load(is_load), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0] op, fn;
    logic [31:0] se, ze;
    op = i[31:26];
    fn = i[5:0];
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    e = '0;
    e.sh = i[10:6];
    e.a1 = rs;
    if (op == 6'b000000) begin
      e.a2 = rt;
      e.dst = i[15:11];
      if (fn == 6'b100000 || fn == 6'b100001) e.op = 5'b00000;
      else if (fn == 6'b100010 || fn == 6'b100011) e.op = 5'b00001;
      else if (fn == 6'b100100) e.op = 5'b00010;
      else if (fn == 6'b100101) e.op = 5'b00011;
      else if (fn == 6'b100111) e.op = 5'b00100;
      else if (fn == 6'b000000) e.op = 5'b00101;
      else if (fn == 6'b000010) e.op = 5'b00110;
      else if (fn == 6'b000011) e.op = 5'b00111;
      else if (fn == 6'b101010) e.op = 5'b01000;
      else e.ill = 1'b1;
    end
    else if (op == 6'b001000 || op == 6'b001001) begin e.op = 5'b00000; e.a2 = se; e.dst = i[20:16]; end
    else if (op == 6'b001010) begin e.op = 5'b01000; e.a2 = se; e.dst = i[20:16]; end
    else if (op == 6'b001100) begin e.op = 5'b00010; e.a2 = ze; e.dst = i[20:16]; end
    else if (op == 6'b001101) begin e.op = 5'b00011; e.a2 = ze; e.dst = i[20:16]; end
    else if (op == 6'b001111) begin e.op = 5'b01001; e.a2 = ze; e.dst = i[20:16]; end
    else if (op == 6'b100011) begin e.op = 5'b00000; e.a2 = se; e.dst = i[20:16]; e.ld = 1'b1; end
    else if (op == 6'b101011) begin e.op = 5'b00000; e.a2 = se; end
    else if (op == 6'b000100) begin e.op = 5'b00001; e.a2 = rt; end
    else if (op == 6'b000101) begin e.op = 5'b01010; e.a2 = rt; end
    else if (op == 6'b000111) e.op = 5'b01011;
    else if (op == 6'b000001 && i[20:16] == 5'b00001) e.op = 5'b01100;
    else e.ill = 1'b1;
    if (e.ill) begin e.op = '0; e.a1 = '0; e.a2 = '0; e.dst = '0; e.ld = 1'b0; end
    return e;
  endfunction

  // One clock: scoreboard push/pop at the falling edge, return 1ns after the rise.
  task automatic tick(output bit acc);
    exp_t e, a;
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (out_valid && out_ready && !rst) begin
      checks++;
      a = {ALU_op, arg1, arg2, shamt, dest_reg, is_load, illegal};
      if (sb.size() == 0) $display("FAIL sb_underflow: got output %h, expected none", a);
      else begin
        e = sb.pop_front();
        if (a !== e) $display("FAIL sb_out: got %h want %h", a, e);
        else passed++;
      end
    end
    if (acc) sb.push_back(model(instr, rs_data, rt_data));
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bit acc;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, ALU_op, arg1, arg2, shamt, dest_reg, is_load, illegal} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {out_valid, ALU_op, arg1, arg2, shamt, dest_reg, is_load, illegal});
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
    instr = 32'h00221820; rs_data = 32'd11; rt_data = 32'd22; in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_async_discard: got out_valid=%b want 0", out_valid);
    else passed++;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    tick(acc);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_release: got out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_basic_add;
    bit acc;
    out_ready = 1'b1;
    instr = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7; in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    checks++;
    if ({acc, out_valid, ALU_op, arg1, arg2, dest_reg} !== {1'b1, 1'b1, 5'd0, 32'd5, 32'd7, 5'd3})
      $display("FAIL basic_add: got acc=%b v=%b op=%h a1=%h a2=%h d=%0d want 1 1 00 5 7 3",
               acc, out_valid, ALU_op, arg1, arg2, dest_reg);
    else passed++;
    tick(acc);
  endtask

  task automatic test_immediates;
    bit acc;
    out_ready = 1'b1;
    instr = 32'h2004FFFF; rs_data = 32'h0; rt_data = 32'h1234; in_valid = 1'b1;
    tick(acc);
    checks++;
    if (arg2 !== 32'hFFFFFFFF || dest_reg !== 5'd4) $display("FAIL addi_sext: got arg2=%h dest=%0d want ffffffff 4", arg2, dest_reg);
    else passed++;
    instr = 32'h3004FFFF;
    tick(acc);
    in_valid = 1'b0;
    checks++;
    if (arg2 !== 32'h0000FFFF || ALU_op !== 5'b00010) $display("FAIL andi_zext: got arg2=%h op=%b want 0000ffff 00010", arg2, ALU_op);
    else passed++;
    tick(acc);
  endtask

  task automatic test_stream(input bit random_ready);
    bit acc;
    int n;
    for (int i = 0; i < N + 4; i++) begin
      instr = (i < N) ? TBL[i] : EXTRA[i - N];
      rs_data = $urandom; rt_data = $urandom; in_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
        out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        tick(acc);
        n++;
      end
      checks++;
      if (!acc) $display("FAIL stream_accept: instr %h not accepted after %0d cycles", instr, n);
      else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick(acc);
  endtask

  task automatic test_load_use;
    bit acc;
    out_ready = 1'b1;
    instr = 32'h8C220000; rs_data = 32'h100; rt_data = 32'h0; in_valid = 1'b1;
    tick(acc);
    instr = 32'h00421820; rs_data = 32'h9; rt_data = 32'h9;
    #1;
    checks++;
    if ({acc, is_load, out_valid, in_ready} !== 4'b1110)
      $display("FAIL lu_held: got acc=%b ld=%b v=%b rdy=%b want 1 1 1 0", acc, is_load, out_valid, in_ready);
    else passed++;
    tick(acc);
    checks++;
    if ({acc, out_valid, in_ready} !== 3'b000)
      $display("FAIL lu_drain: got acc=%b v=%b rdy=%b want 0 0 0", acc, out_valid, in_ready);
    else passed++;
    tick(acc);
    checks++;
    if ({acc, in_ready} !== 2'b01) $display("FAIL lu_release: got acc=%b rdy=%b want 0 1", acc, in_ready);
    else passed++;
    tick(acc);
    checks++;
    if ({acc, out_valid, dest_reg} !== {2'b11, 5'd3}) $display("FAIL lu_issue: got acc=%b v=%b d=%0d want 1 1 3", acc, out_valid, dest_reg);
    else passed++;
    instr = 32'h8C220000;
    tick(acc);
    instr = 32'h30820001;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL lu_itype_rt: got rdy=%b want 1", in_ready);
    else passed++;
    tick(acc);
    in_valid = 1'b0;
    repeat (3) tick(acc);
  endtask

  task automatic test_stall;
    bit acc;
    exp_t snap;
    out_ready = 1'b0;
    instr = 32'h34278001; rs_data = 32'hA5A5_0000; rt_data = 32'h1; in_valid = 1'b1;
    tick(acc);
    snap = {ALU_op, arg1, arg2, shamt, dest_reg, is_load, illegal};
    instr = 32'h00221820; rs_data = 32'h3; rt_data = 32'h4;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      checks++;
      if (acc || !out_valid || in_ready || {ALU_op, arg1, arg2, shamt, dest_reg, is_load, illegal} !== snap)
        $display("FAIL stall_hold%0d: got acc=%b v=%b rdy=%b out=%h want 0 1 0 %h", k, acc, out_valid, in_ready,
                 {ALU_op, arg1, arg2, shamt, dest_reg, is_load, illegal}, snap);
      else passed++;
    end
    out_ready = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    checks++;
    if ({acc, out_valid, arg1} !== {2'b11, 32'h3}) $display("FAIL stall_release: got acc=%b v=%b a1=%h want 1 1 3", acc, out_valid, arg1);
    else passed++;
    repeat (2) tick(acc);
  endtask

  task automatic test_flush;
    bit acc;
    out_ready = 1'b0;
    instr = 32'h8C220000; rs_data = 32'h40; rt_data = 32'h0; in_valid = 1'b1;
    tick(acc);
    instr = 32'h00421820; flush = 1'b1;
    tick(acc);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({acc, out_valid, in_ready} !== 3'b001) $display("FAIL flush_kill: got acc=%b v=%b rdy=%b want 0 0 1", acc, out_valid, in_ready);
    else passed++;
    out_ready = 1'b1;
    instr = 32'hFC000000; rs_data = 32'hDEAD; rt_data = 32'hBEEF; in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, illegal, ALU_op, arg1, arg2, dest_reg, is_load} !== {2'b11, 5'd0, 64'd0, 5'd0, 1'b0})
      $display("FAIL illegal_op: got v=%b ill=%b op=%b a1=%h a2=%h d=%0d ld=%b want 1 1 0 0 0 0 0",
               out_valid, illegal, ALU_op, arg1, arg2, dest_reg, is_load);
    else passed++;
    repeat (2) tick(acc);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_immediates();
    test_stream(1'b0);
    test_load_use();
    test_stall();
    test_flush();
    test_stream(1'b1);
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d results never produced, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
